// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw active-low keys and enable in, debounced
// level and single-cycle press/release pulses out.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic                enable;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic                any_held;

    modport master (
        output key_n, enable,
        input  held, press_pulse, release_pulse, any_held
    );

    modport slave (
        input  key_n, enable,
        output held, press_pulse, release_pulse, any_held
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key 2-flop synchronizer, debounce FSM and registered held/press/release outputs.
// Optional auto-repeat of press_pulse while held: define KEY_CONDITIONER_AUTO_REPEAT_EN.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic             clk,
    input  logic             reset_n,
    key_conditioner_if.slave kif
);
    localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q, s;
    key_state_e          state_q [NUM_KEYS];
    key_state_e          state_d [NUM_KEYS];
    cnt_t                cnt_q   [NUM_KEYS];
    cnt_t                cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                any_held_q, any_held_d;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
    localparam cnt_t REP_DELAY_LAST = cnt_t'(REPEAT_DELAY - 1);
    localparam cnt_t REP_RATE_LAST  = cnt_t'(REPEAT_RATE - 1);
    // Selects the initial delay vs. the steady repeat interval for the counter.
    logic [NUM_KEYS-1:0] rep_first_q, rep_first_d;
`endif

    assign s = ~sync2_q;

    always_comb begin
        held_d    = held_q;
        press_d   = '0;
        release_d = '0;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
        rep_first_d = rep_first_q;
`endif
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                RELEASED: begin
                    if (s[i]) begin
                        state_d[i] = PRESS_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!s[i]) begin
                        state_d[i] = RELEASED;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = HELD;
                        held_d[i]  = 1'b1;
                        press_d[i] = kif.enable;
                        cnt_d[i]   = '0;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
                        rep_first_d[i] = 1'b1;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + cnt_t'(1);
                    end
                end
                HELD: begin
                    if (!s[i]) begin
                        state_d[i] = REL_CHK;
                        cnt_d[i]   = '0;
                    end
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
                    else if (cnt_q[i] == (rep_first_q[i] ? REP_DELAY_LAST : REP_RATE_LAST)) begin
                        press_d[i]     = kif.enable;
                        cnt_d[i]       = '0;
                        rep_first_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + cnt_t'(1);
                    end
`endif
                end
                REL_CHK: begin
                    if (s[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
                        rep_first_d[i] = 1'b1;
`endif
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i]   = RELEASED;
                        held_d[i]    = 1'b0;
                        release_d[i] = kif.enable;
                        cnt_d[i]     = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + cnt_t'(1);
                    end
                end
                default: state_d[i] = RELEASED;
            endcase
        end
        any_held_d = |held_d;
    end

    // Synchronizers reset to 1 so a key reads as released out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            held_q     <= '0;
            press_q    <= '0;
            release_q  <= '0;
            any_held_q <= 1'b0;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
            rep_first_q <= '0;
`endif
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q    <= kif.key_n;
            sync2_q    <= sync1_q;
            held_q     <= held_d;
            press_q    <= press_d;
            release_q  <= release_d;
            any_held_q <= any_held_d;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
            rep_first_q <= rep_first_d;
`endif
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign kif.held          = held_q;
    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.any_held      = any_held_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Randomized and directed bench for key_conditioner against a run-length
// debounce model; build with KEY_CONDITIONER_AUTO_REPEAT_EN to cover auto-repeat.
module tb_key_conditioner;
    localparam int D = 4;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
    localparam int RD = 10;
    localparam int RR = 5;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    key_conditioner_if #(.NUM_KEYS(4)) kif ();

    key_conditioner #(
        .NUM_KEYS       (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kif    (kif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the debounced level flips once the synchronized input has
    // disagreed with it on D+1 consecutive clock edges.
    logic [3:0] m_kd1, m_kd2, m_held, m_press, m_rel;
    int         run [4];
    int         t   [4];

    task automatic model_reset();
        m_kd1 = 4'hF; m_kd2 = 4'hF;
        m_held = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < 4; i++) begin run[i] = 0; t[i] = 0; end
    endtask

    task automatic model_step();
        logic [3:0] s;
        s = ~m_kd2;
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] != m_held[i]) begin
                run[i]++;
                t[i] = 0;
                if (run[i] == D + 1) begin
                    m_held[i] = s[i];
                    run[i] = 0;
                    if (s[i]) m_press[i] = kif.enable;
                    else      m_rel[i]   = kif.enable;
                end
            end else begin
                if (m_held[i] && run[i] == 0) begin
                    t[i]++;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
                    if (t[i] == RD || (t[i] > RD && (t[i] - RD) % RR == 0))
                        m_press[i] = kif.enable;
`endif
                end else begin
                    t[i] = 0;
                end
                run[i] = 0;
            end
        end
        m_kd2 = m_kd1;
        m_kd1 = kif.key_n;
    endtask

    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else          model_step();
        #1;
        check("held",     int'(kif.held),          int'(m_held));
        check("press",    int'(kif.press_pulse),   int'(m_press));
        check("release",  int'(kif.release_pulse), int'(m_rel));
        check("any_held", int'(kif.any_held),      int'(|m_held));
    end

    task automatic watch(input int n, input int key, input bit use_rel,
                         output int first, output int cnt, output logic h);
        first = -1; cnt = 0; h = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (use_rel ? kif.release_pulse[key] : kif.press_pulse[key]) begin
                if (first < 0) begin first = i; h = kif.held[key]; end
                cnt++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first, cnt, acc, idx;
        logic h;
        logic [3:0] vec, orv;
        logic any_at;

        kif.key_n  = 4'hF;
        kif.enable = 1'b1;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        kif.key_n = 4'b1110;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({kif.held, kif.press_pulse, kif.release_pulse, kif.any_held}), 0);
        reset_n = 1'b1;
        watch(10, 0, 0, first, cnt, h);
        check("reset_press_edge", first, 6);
        check("reset_press_count", cnt, 1);
        check("reset_held_at_press", int'(h), 1);
        check("reset_held_after", int'(kif.held[0]), 1);

        // Bounce on key 1: 3-cycle glitch then stable press.
        @(negedge clk); kif.key_n[1] = 1'b0;
        watch(3, 1, 0, first, acc, h);
        @(negedge clk); kif.key_n[1] = 1'b1;
        watch(1, 1, 0, first, cnt, h);
        acc += cnt;
        check("bounce_glitch_pulses", acc, 0);
        @(negedge clk); kif.key_n[1] = 1'b0;
        watch(10, 1, 0, first, cnt, h);
        check("bounce_press_edge", first, 6);
        check("bounce_press_count", cnt, 1);

        // Release on key 2 with a 2-cycle glitch first.
        @(negedge clk); kif.key_n[2] = 1'b0;
        watch(10, 2, 0, first, cnt, h);
        check("k2_press_edge", first, 6);
        @(negedge clk); kif.key_n[2] = 1'b1;
        watch(2, 2, 1, first, acc, h);
        @(negedge clk); kif.key_n[2] = 1'b0;
        watch(10, 2, 1, first, cnt, h);
        acc += cnt;
        check("rel_glitch_pulses", acc, 0);
        check("rel_glitch_held", int'(kif.held[2]), 1);
        @(negedge clk); kif.key_n[2] = 1'b1;
        watch(10, 2, 1, first, cnt, h);
        check("release_edge", first, 6);
        check("release_count", cnt, 1);
        check("release_held_same_cycle", int'(h), 0);

        // Simultaneous press on all keys.
        @(negedge clk); kif.key_n = 4'hF;
        repeat (12) @(negedge clk);
        kif.key_n = 4'h0;
        idx = -1; vec = '0; any_at = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (idx < 0 && kif.press_pulse != 4'h0) begin
                idx = i; vec = kif.press_pulse; any_at = kif.any_held;
            end
        end
        check("concurrent_edge", idx, 6);
        check("concurrent_vec", int'(vec), 15);
        check("concurrent_any_held", int'(any_at), 1);

        // enable=0 suppresses pulses while held still tracks.
        @(negedge clk); kif.key_n = 4'hF;
        repeat (12) @(negedge clk);
        kif.enable = 1'b0;
        kif.key_n  = 4'h0;
        orv = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            orv |= kif.press_pulse;
        end
        check("disabled_press", int'(orv), 0);
        check("disabled_held", int'(kif.held), 15);
`ifndef KEY_CONDITIONER_AUTO_REPEAT_EN
        @(negedge clk); kif.enable = 1'b1;
        orv = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            orv |= kif.press_pulse;
        end
        check("enable_raise_no_pulse", int'(orv), 0);
`endif

        // Reset during REL_CHK on key 0.
        @(negedge clk); kif.enable = 1'b1; kif.key_n = 4'b1110;
        repeat (12) @(negedge clk);
        kif.key_n = 4'hF;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_held_before", int'(kif.held[0]), 1);
        #2 reset_n = 1'b0;
        #1 check("midrst_async_outputs", int'({kif.held, kif.press_pulse, kif.release_pulse, kif.any_held}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        watch(10, 0, 1, first, cnt, h);
        check("midrst_no_release", cnt, 0);

        // Long hold on key 3.
        @(negedge clk); kif.key_n[3] = 1'b0;
        watch(46, 3, 0, first, cnt, h);
        check("hold_first_press", first, 6);
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
        check("hold_press_count", cnt, 7);
`else
        check("hold_press_count", cnt, 1);
`endif
        @(negedge clk); kif.key_n = 4'hF;
        repeat (10) @(negedge clk);

        // Random segments, checked cycle by cycle against the model.
        for (int seg = 0; seg < 400; seg++) begin
            int dur;
            kif.key_n  = kif.key_n ^ 4'($urandom_range(0, 15));
            kif.enable = ($urandom_range(0, 7) != 0);
            dur = $urandom_range(1, 9);
            if ($urandom_range(0, 3) == 0) dur += 20;
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
            end
            repeat (dur) @(negedge clk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
